fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Program-counter and IF/ID stage of the single-issue MIPS datapath. Drives the word-indexed
//  program_counter into the instruction memory (combinational read, same cycle) and registers the
//  returned instruction into the IF/ID register. Handles stall, taken branch and jump redirects
//  resolved in ID. Stops fetching once the PC leaves the loaded program.
// PARAMETERS
//  RESET_PC     32'd0   PC value loaded on reset (word index)
//  INSTR_COUNT  3       number of instructions loaded in instruction memory; PC >= this is out of range
// PORTS
//  clk               in   1   rising-edge clock
//  reset             in   1   synchronous, active-high reset
//  stall             in   1   hazard unit: hold PC and IF/ID
//  branch_taken      in   1   ID: branch in IF/ID is taken
//  branch_offset     in   16  ID: signed word offset, relative to ifid_pc_plus1
//  jump              in   1   ID: instruction in IF/ID is a jump
//  jump_target       in   26  ID: jump target field (word index)
//  instruction_in    in   32  instruction memory data for program_counter
//  program_counter   out  32  word index to instruction memory
//  ifid_instruction  out  32  IF/ID instruction
//  ifid_pc_plus1     out  32  IF/ID program_counter+1 of the held instruction
//  ifid_valid        out  1   IF/ID holds a real instruction
//  done              out  1   program_counter is >= INSTR_COUNT
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high. Reset dominates all inputs:
//    program_counter=RESET_PC, ifid_instruction=NOP (32'h0), ifid_pc_plus1=0, ifid_valid=0,
//    done=(RESET_PC>=INSTR_COUNT).
//  - All state updates on rising clk. Per-cycle priority: reset > jump > branch_taken > stall > advance.
//  - jump: PC <= {ifid_pc_plus1[31:26], jump_target}; IF/ID flushed (NOP, pc_plus1=0, valid=0).
//  - branch_taken: PC <= ifid_pc_plus1 + sext32(branch_offset), mod 2^32; IF/ID flushed.
//  - Redirect ignored (treated as 0) when ifid_valid=0. Redirect overrides stall in the same cycle.
//  - stall (no valid redirect): PC, IF/ID and done hold.
//  - advance, PC < INSTR_COUNT: PC <= PC+1; IF/ID <= {instruction_in, PC+1, valid=1}.
//  - advance, PC >= INSTR_COUNT: PC holds; instruction_in ignored; IF/ID <= NOP, valid=0.
//  - done is registered: updated on every PC load to (next PC >= INSTR_COUNT), unsigned compare;
//    a redirect back into range clears it.
//  - Arithmetic 32-bit unsigned wrap; negative branch target below 0 wraps high -> out of range -> done=1.
//  - Latency: instruction at PC=n is in IF/ID one cycle after PC=n is presented; redirect takes effect
//    on program_counter the cycle after branch_taken/jump is sampled (1 bubble).
// STRUCTURE
//  - Shared package mips_pkg: WORD_W=32, NOP_INSTR=32'h0, function sext16to32.
//  - One sub-module: next_pc_select (combinational: priority mux producing next PC, flush and load_ifid
//    controls). Registers (PC, IF/ID, done) stay in fetch_pc_unit.
// TESTING
//  - Reset then 3 free cycles, mem={A,B,C}: PC 0->1->2->3; IF/ID A(pc+1=1),B(2),C(3) valid; done=1 at PC=3.
//  - PC=3 further cycles: PC stays 3, ifid_valid=0, ifid_instruction=0, done stays 1.
//  - stall=1 for 2 cycles at PC=1: PC=1 and IF/ID=A held both cycles; resumes with B.
//  - IF/ID valid, pc_plus1=2, branch_taken, offset=16'hFFFF: next PC=1, IF/ID flushed valid=0.
//  - jump with jump_target=0 and stall=1 same cycle: PC=0, flush, done cleared; stall ignored.
//  - Reset asserted mid-run at PC=2 with jump=1: PC=RESET_PC, IF/ID NOP, valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS datapath.
// Holds the IF/ID bundle layout and the sign-extension helper.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus1;
        logic              valid;
    } if_id_t;

    function automatic logic [WORD_W-1:0] sext16to32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: redirect controls, imem data and IF/ID outputs.
// slave = fetch unit, master = hazard/ID/imem side.
interface fetch_pc_unit_if;
    import mips_pkg::*;

    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_offset;
    logic              jump;
    logic [25:0]       jump_target;
    logic [WORD_W-1:0] instruction_in;
    logic [WORD_W-1:0] program_counter;
    logic [WORD_W-1:0] ifid_instruction;
    logic [WORD_W-1:0] ifid_pc_plus1;
    logic              ifid_valid;
    logic              done;

    modport slave (
        input  stall, branch_taken, branch_offset,
        input  jump, jump_target, instruction_in,
        output program_counter, ifid_instruction,
        output ifid_pc_plus1, ifid_valid, done
    );

    modport master (
        output stall, branch_taken, branch_offset,
        output jump, jump_target, instruction_in,
        input  program_counter, ifid_instruction,
        input  ifid_pc_plus1, ifid_valid, done
    );

endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// Next-PC priority mux: jump > branch > stall > advance.
// Redirects only count when IF/ID holds a real instruction.
module next_pc_select
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] INSTR_COUNT = 32'd3
) (
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] ifid_pc_plus1_i,
    input  logic              ifid_valid_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_offset_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_target_i,
    output logic [WORD_W-1:0] pc_d_o,
    output logic              pc_load_o,
    output logic              flush_o,
    output logic              load_ifid_o
);

    logic do_jump;
    logic do_branch;
    logic in_range;

    assign do_jump   = jump_i & ifid_valid_i;
    assign do_branch = branch_taken_i & ifid_valid_i;
    assign in_range  = pc_i < INSTR_COUNT;

    // Select the single action for this cycle in priority order.
    always_comb begin
        pc_d_o      = pc_i;
        pc_load_o   = 1'b0;
        flush_o     = 1'b0;
        load_ifid_o = 1'b0;
        priority case (1'b1)
            do_jump: begin
                pc_d_o    = {ifid_pc_plus1_i[31:26], jump_target_i};
                pc_load_o = 1'b1;
                flush_o   = 1'b1;
            end
            do_branch: begin
                pc_d_o    = ifid_pc_plus1_i + sext16to32(branch_offset_i);
                pc_load_o = 1'b1;
                flush_o   = 1'b1;
            end
            stall_i: begin
                pc_d_o = pc_i;
            end
            in_range: begin
                pc_d_o      = pc_i + 32'd1;
                pc_load_o   = 1'b1;
                load_ifid_o = 1'b1;
            end
            default: begin
                flush_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and IF/ID pipeline register of the MIPS fetch stage.
// Next-state selection lives in next_pc_select.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 32'd0,
    parameter logic [WORD_W-1:0] INSTR_COUNT = 32'd3
) (
    input  logic          clk,
    input  logic          reset,
    fetch_pc_unit_if.slave bus
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    if_id_t            ifid_q;
    logic              done_q;
    logic              pc_load;
    logic              flush;
    logic              load_ifid;

    next_pc_select #(
        .INSTR_COUNT(INSTR_COUNT)
    ) u_next_pc (
        .pc_i            (pc_q),
        .ifid_pc_plus1_i (ifid_q.pc_plus1),
        .ifid_valid_i    (ifid_q.valid),
        .stall_i         (bus.stall),
        .branch_taken_i  (bus.branch_taken),
        .branch_offset_i (bus.branch_offset),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .pc_d_o          (pc_d),
        .pc_load_o       (pc_load),
        .flush_o         (flush),
        .load_ifid_o     (load_ifid)
    );

    // PC and done flag; done tracks every PC load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            done_q <= RESET_PC >= INSTR_COUNT;
        end else if (pc_load) begin
            pc_q   <= pc_d;
            done_q <= pc_d >= INSTR_COUNT;
        end
    end

    // IF/ID register: flush to NOP, capture fetch, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus1: '0, valid: 1'b0};
        end else if (flush) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus1: '0, valid: 1'b0};
        end else if (load_ifid) begin
            ifid_q <= '{instr: bus.instruction_in, pc_plus1: pc_d, valid: 1'b1};
        end
    end

    assign bus.program_counter  = pc_q;
    assign bus.ifid_instruction = ifid_q.instr;
    assign bus.ifid_pc_plus1    = ifid_q.pc_plus1;
    assign bus.ifid_valid       = ifid_q.valid;
    assign bus.done             = done_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, then random
// stimulus against a cycle-level reference model.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC    (32'd0),
        .INSTR_COUNT (32'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [3];
    logic [31:0] junk;

    always_comb begin
        if (bus.program_counter < 32'd3)
            bus.instruction_in = mem[bus.program_counter[1:0]];
        else
            bus.instruction_in = junk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        s;
        logic        b;
        logic [15:0] o;
        logic        j;
        logic [25:0] t;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp;
        logic        v;
        logic        d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic b, logic [15:0] o,
                                logic j, logic [25:0] t, logic [31:0] pc,
                                logic [31:0] ins, logic [31:0] pp,
                                logic v, logic d);
        vec_t x;
        x.r = r; x.s = s; x.b = b; x.o = o; x.j = j; x.t = t;
        x.pc = pc; x.ins = ins; x.pp = pp; x.v = v; x.d = d;
        return x;
    endfunction

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [15:0] o, input logic j,
                         input logic [25:0] t);
        reset            = r;
        bus.stall        = s;
        bus.branch_taken = b;
        bus.branch_offset = o;
        bus.jump         = j;
        bus.jump_target  = t;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] pp,
                             input logic v, input logic d);
        chk({tag, ".pc"},    bus.program_counter, pc);
        chk({tag, ".instr"}, bus.ifid_instruction, ins);
        chk({tag, ".pp1"},   bus.ifid_pc_plus1, pp);
        chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
        chk({tag, ".done"},  {31'd0, bus.done}, {31'd0, d});
    endtask

    localparam logic [31:0] A = 32'hAAAA0001;
    localparam logic [31:0] B = 32'hBBBB0002;
    localparam logic [31:0] C = 32'hCCCC0003;
    localparam logic [31:0] M1 = 32'hFFFFFFFF;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pp;
    logic        m_v;
    logic        m_d;

    initial begin
        mem[0] = A; mem[1] = B; mem[2] = C;
        junk = 32'hDEADBEEF;
        drive(1, 0, 0, 16'h0, 0, 26'h0);

        vecs.push_back(mk(1,0,0,16'h0,   0,26'd0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 2,B,2,1,0));
        vecs.push_back(mk(0,0,1,16'hFFFF,0,26'd0, 1,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 2,B,2,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 3,C,3,1,1));
        vecs.push_back(mk(0,1,0,16'h0,   1,26'd0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 2,B,2,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 3,C,3,1,1));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 3,0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 3,0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0,   1,26'd1, 3,0,0,0,1));
        vecs.push_back(mk(0,0,1,16'hFFFE,0,26'd0, 3,0,0,0,1));
        vecs.push_back(mk(1,0,0,16'h0,   1,26'd2, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,0,1,16'hFFFE,0,26'd0, M1,0,0,0,1));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, M1,0,0,0,1));
        vecs.push_back(mk(1,0,0,16'h0,   0,26'd0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   1,26'd2, 2,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 3,C,3,1,1));
        vecs.push_back(mk(1,0,0,16'h0,   0,26'd0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 1,A,1,1,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,26'd0, 2,B,2,1,0));
        vecs.push_back(mk(1,0,0,16'h0,   1,26'd1, 0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].o,
                  vecs[i].j, vecs[i].t);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ins,
                      vecs[i].pp, vecs[i].v, vecs[i].d);
        end

        // random phase against the reference model
        m_pc = 0; m_ins = 0; m_pp = 0; m_v = 0; m_d = 0;
        for (int n = 0; n < 400; n++) begin
            logic        r, s, b, j;
            logic [15:0] o;
            logic [25:0] t;
            logic [31:0] fetched;
            r = ($urandom_range(99) < 3);
            s = ($urandom_range(99) < 30);
            b = ($urandom_range(99) < 15);
            j = ($urandom_range(99) < 10);
            o = 16'($signed($urandom_range(8)) - 4);
            t = 26'($urandom_range(4));
            junk = $urandom;
            if ($urandom_range(9) == 0) begin
                mem[0] = $urandom; mem[1] = $urandom; mem[2] = $urandom;
            end
            fetched = (m_pc < 3) ? mem[m_pc[1:0]] : junk;
            drive(r, s, b, o, j, t);
            if (r) begin
                m_pc = 0; m_ins = 0; m_pp = 0; m_v = 0; m_d = 0;
            end else if (j && m_v) begin
                m_pc = {m_pp[31:26], t};
                m_ins = 0; m_pp = 0; m_v = 0;
                m_d = (m_pc >= 3);
            end else if (b && m_v) begin
                m_pc = m_pp + {{16{o[15]}}, o};
                m_ins = 0; m_pp = 0; m_v = 0;
                m_d = (m_pc >= 3);
            end else if (s) begin
                // everything holds
            end else if (m_pc < 3) begin
                m_ins = fetched;
                m_pc = m_pc + 1;
                m_pp = m_pc;
                m_v = 1;
                m_d = (m_pc >= 3);
            end else begin
                m_ins = 0; m_pp = 0; m_v = 0;
            end
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", n), m_pc, m_ins, m_pp, m_v, m_d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
